// File: rtl/disp_scan_arbiter.sv
// Shares a 4-digit 7-segment display between two requesters.
// Ownership and displayed values change only at frame boundaries.
module disp_scan_arbiter #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 2,
    parameter int HOLD_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic [3:0]  dp_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    input  logic [3:0]  dp_b,
    input  logic        blank_lz,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        frame_done,
    output logic [7:0]  Dis_data,
    output logic [3:0]  Dis_wich
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_MIN  = HW'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    state_t        r_state;
    logic [HW-1:0] r_hold;
    logic          r_last_b;
    logic [15:0]   r_sh_data;
    logic [3:0]    r_sh_dp;
    logic          r_fd;
    logic [3:0]    r_wich;
    logic [7:0]    r_data;

    logic          w_tick;
    logic          w_fb;
    state_t        w_nxt_state;
    logic [HW-1:0] w_nxt_hold;
    logic [HW-1:0] w_hold_inc;
    logic          w_nxt_last_b;
    logic [15:0]   w_nxt_data;
    logic [3:0]    w_nxt_dp;
    logic [3:0]    w_nib;
    logic          w_lz;
    logic          w_on;
    logic [6:0]    w_seg;
    logic [3:0]    w_wich;
    logic [7:0]    w_data;

    assign w_tick = (r_cnt == CNT_LAST);
    assign w_fb   = w_tick && (r_idx == 2'd3);

    // Segment pattern without the dp bit, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] f_seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_hold   = r_hold;
        w_nxt_last_b = r_last_b;
        w_hold_inc   = (r_hold == HOLD_MIN) ? r_hold : r_hold + HW'(1);
        unique case (r_state)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    w_nxt_state = r_last_b ? ST_OWN_A : ST_OWN_B;
                end else if (req_a) begin
                    w_nxt_state = ST_OWN_A;
                end else if (req_b) begin
                    w_nxt_state = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!req_a) begin
                    w_nxt_state = req_b ? ST_OWN_B : ST_IDLE;
                end else begin
                    w_nxt_hold = w_hold_inc;
                    if (w_hold_inc >= HOLD_MIN && req_b) begin
                        w_nxt_state = ST_OWN_B;
                    end
                end
            end
            ST_OWN_B: begin
                if (!req_b) begin
                    w_nxt_state = req_a ? ST_OWN_A : ST_IDLE;
                end else begin
                    w_nxt_hold = w_hold_inc;
                    if (w_hold_inc >= HOLD_MIN && req_a) begin
                        w_nxt_state = ST_OWN_A;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        if (w_nxt_state != r_state) begin
            w_nxt_hold = '0;
            if (w_nxt_state == ST_OWN_A) begin
                w_nxt_last_b = 1'b0;
            end else if (w_nxt_state == ST_OWN_B) begin
                w_nxt_last_b = 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt_data = '0;
        w_nxt_dp   = '0;
        case (w_nxt_state)
            ST_OWN_A: begin
                w_nxt_data = data_a;
                w_nxt_dp   = dp_a;
            end
            ST_OWN_B: begin
                w_nxt_data = data_b;
                w_nxt_dp   = dp_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_last_b  <= 1'b1;
            r_sh_data <= '0;
            r_sh_dp   <= '0;
        end else if (w_fb) begin
            r_state   <= w_nxt_state;
            r_hold    <= w_nxt_hold;
            r_last_b  <= w_nxt_last_b;
            r_sh_data <= w_nxt_data;
            r_sh_dp   <= w_nxt_dp;
        end
    end

    // A digit is a leading zero when it and every higher nibble is zero
    always_comb begin
        w_nib = r_sh_data[3:0];
        w_lz  = 1'b0;
        unique case (r_idx)
            2'd0: begin
                w_nib = r_sh_data[3:0];
                w_lz  = 1'b0;
            end
            2'd1: begin
                w_nib = r_sh_data[7:4];
                w_lz  = (r_sh_data[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib = r_sh_data[11:8];
                w_lz  = (r_sh_data[15:8] == 8'd0);
            end
            2'd3: begin
                w_nib = r_sh_data[15:12];
                w_lz  = (r_sh_data[15:12] == 4'd0);
            end
        endcase
    end

    always_comb begin
        w_seg  = f_seg7(w_nib);
        w_on   = (r_state != ST_IDLE) && (r_cnt >= BLANK_END);
        w_wich = 4'hF;
        w_data = 8'hFF;
        if (w_on) begin
            w_wich = ~(4'b0001 << r_idx);
            if (!(blank_lz && w_lz)) begin
                w_data = {~r_sh_dp[r_idx], w_seg};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fd   <= 1'b0;
            r_wich <= 4'hF;
            r_data <= 8'hFF;
        end else begin
            r_fd   <= w_fb;
            r_wich <= w_wich;
            r_data <= w_data;
        end
    end

    assign gnt_a      = (r_state == ST_OWN_A);
    assign gnt_b      = (r_state == ST_OWN_B);
    assign frame_done = r_fd;
    assign Dis_wich   = r_wich;
    assign Dis_data   = r_data;

endmodule

// File: tb/tb_disp_scan_arbiter.sv
// Bench for disp_scan_arbiter: frame-position reference model plus
// directed literal checks and a randomized soak.
module tb_disp_scan_arbiter;

    localparam int SD    = 4;
    localparam int BL    = 1;
    localparam int HF    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] data_a = '0;
    logic [15:0] data_b = '0;
    logic [3:0]  dp_a = '0;
    logic [3:0]  dp_b = '0;
    logic        blank_lz = 1'b0;
    logic        gnt_a;
    logic        gnt_b;
    logic        frame_done;
    logic [7:0]  Dis_data;
    logic [3:0]  Dis_wich;

    disp_scan_arbiter #(
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BL),
        .HOLD_FRAMES(HF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .dp_a      (dp_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .dp_b      (dp_b),
        .blank_lz  (blank_lz),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .frame_done(frame_done),
        .Dis_data  (Dis_data),
        .Dis_wich  (Dis_wich)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Model: owner 0=none 1=A 2=B; position in frame from a cycle count
    bit          m_valid = 1'b0;
    int          m_cyc, m_own, m_hold, m_last;
    logic [15:0] m_sh;
    logic [3:0]  m_shdp;
    logic [1:0]  e_gnt;
    logic        e_fd;
    logic [3:0]  e_wich;
    logic [7:0]  e_data;
    int          p_m, cnt_m, idx_m, nxt_m, oth_m;
    bit          fb_m, own_req, oth_req;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            m_own   = 0;
            m_hold  = 0;
            m_last  = 2;
            m_sh    = '0;
            m_shdp  = '0;
            e_gnt   = 2'b00;
            e_fd    = 1'b0;
            e_wich  = 4'hF;
            e_data  = 8'hFF;
        end else if (m_valid) begin
            p_m   = m_cyc % FRAME;
            cnt_m = p_m % SD;
            idx_m = p_m / SD;
            fb_m  = (p_m == FRAME - 1);
            if (m_own == 0 || cnt_m < BL) begin
                e_wich = 4'hF;
                e_data = 8'hFF;
            end else begin
                e_wich = ~(4'b0001 << idx_m);
                if (blank_lz && idx_m > 0 && (m_sh >> (4 * idx_m)) == 0) begin
                    e_data = 8'hFF;
                end else begin
                    e_data = seg_tab[m_sh[4*idx_m +: 4]];
                    if (m_shdp[idx_m]) e_data[7] = 1'b0;
                end
            end
            e_fd = fb_m;
            if (fb_m) begin
                nxt_m = m_own;
                if (m_own == 0) begin
                    if (req_a && req_b) nxt_m = (m_last == 1) ? 2 : 1;
                    else if (req_a) nxt_m = 1;
                    else if (req_b) nxt_m = 2;
                end else begin
                    own_req = (m_own == 1) ? req_a : req_b;
                    oth_req = (m_own == 1) ? req_b : req_a;
                    oth_m   = 3 - m_own;
                    if (!own_req) begin
                        nxt_m = oth_req ? oth_m : 0;
                    end else begin
                        m_hold++;
                        if (m_hold >= HF && oth_req) nxt_m = oth_m;
                    end
                end
                if (nxt_m != m_own) begin
                    m_hold = 0;
                    if (nxt_m != 0) m_last = nxt_m;
                end
                m_own = nxt_m;
                m_sh   = (m_own == 1) ? data_a : (m_own == 2) ? data_b : 16'h0;
                m_shdp = (m_own == 1) ? dp_a : (m_own == 2) ? dp_b : 4'h0;
            end
            e_gnt = {m_own == 1, m_own == 2};
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("gnt", {30'd0, gnt_a, gnt_b}, {30'd0, e_gnt});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
            chk("wich", {28'd0, Dis_wich}, {28'd0, e_wich});
            chk("data", {24'd0, Dis_data}, {24'd0, e_data});
        end
    end

    task automatic wait_fd(input int budget, input string what);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        chk({what, "_fd_seen"}, {31'd0, seen}, 32'd1);
    endtask

    // Expects to start on a frame_done negedge; ends on the next one
    task automatic check_frame(input logic [31:0] digs, input string what);
        logic [3:0] w;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            if (j % SD == 0) begin
                chk({what, "_wich_blank"}, {28'd0, Dis_wich}, 32'hF);
                chk({what, "_data_blank"}, {24'd0, Dis_data}, 32'hFF);
            end else begin
                w = 4'b0001 << (j / SD);
                chk({what, "_wich"}, {28'd0, Dis_wich}, {28'd0, ~w});
                chk({what, "_data"}, {24'd0, Dis_data},
                    {24'd0, digs[8*(j/SD) +: 8]});
            end
        end
    endtask

    task automatic count_to_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 3 * FRAME);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [9:0] seq;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wich", {28'd0, Dis_wich}, 32'hF);
        chk("rst_data", {24'd0, Dis_data}, 32'hFF);
        reset = 1'b1;

        count_to_fd(n);
        chk("t1_first_fd", n, FRAME);
        count_to_fd(n);
        chk("t1_fd_period", n, FRAME);
        chk("t1_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);

        req_a  = 1'b1;
        data_a = 16'h12AF;
        dp_a   = 4'h0;
        wait_fd(2 * FRAME, "t2");
        chk("t2_gnt", {30'd0, gnt_a, gnt_b}, 32'b10);
        check_frame(32'hF9A4_888E, "t2");

        repeat (6) @(negedge clk);
        data_a = 16'h3456;
        dp_a   = 4'hF;
        req_a  = 1'b0;
        wait_fd(2 * FRAME, "t4");
        chk("t4_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        @(negedge clk);
        chk("t4_wich", {28'd0, Dis_wich}, 32'hF);

        req_a    = 1'b1;
        blank_lz = 1'b1;
        data_a   = 16'h0005;
        dp_a     = 4'b0001;
        wait_fd(2 * FRAME, "t5");
        data_a = 16'h0000;
        dp_a   = 4'b0000;
        check_frame(32'hFFFF_FF12, "t5a");
        check_frame(32'hFFFF_FFC0, "t5b");
        blank_lz = 1'b0;

        reset = 1'b0;
        req_a = 1'b1;
        req_b = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seq = 10'b10_01_01_10_10;
        for (int k = 0; k < 5; k++) begin
            wait_fd(2 * FRAME, "t3");
            chk("t3_gnt", {30'd0, gnt_a, gnt_b}, {30'd0, seq[2*k +: 2]});
        end

        req_a = 1'b0;
        wait_fd(2 * FRAME, "t6");
        chk("t6_gnt_b", {30'd0, gnt_a, gnt_b}, 32'b01);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
        chk("t6_fd", {31'd0, frame_done}, 32'd0);
        chk("t6_wich", {28'd0, Dis_wich}, 32'hF);
        chk("t6_data", {24'd0, Dis_data}, 32'hFF);
        reset = 1'b1;
        count_to_fd(n);
        chk("t6_restart", n, FRAME);
        chk("t6_regrant", {30'd0, gnt_a, gnt_b}, 32'b01);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) req_a = ~req_a;
            if ($urandom_range(15) == 0) req_b = ~req_b;
            if ($urandom_range(7) == 0) data_a = 16'($urandom);
            if ($urandom_range(7) == 0) data_b = 16'($urandom_range(255));
            if ($urandom_range(7) == 0) dp_a = 4'($urandom);
            if ($urandom_range(7) == 0) dp_b = 4'($urandom);
            if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(999) != 0);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
